// File: rtl/seq_divider16.sv
// 32/16 unsigned restoring divider: one quotient bit per clock.
// Zero-divisor and quotient-overflow cases are detected up front and finish in two cycles.
module seq_divider16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t      state_q;
  logic [31:0] dvd_q;
  logic [15:0] dvs_q;
  logic [16:0] pr_q;
  logic [15:0] sr_q;
  logic [3:0]  cnt_q;
  logic [15:0] quot_q;
  logic [15:0] rem_q;
  logic        dbz_q;
  logic        ovf_q;

  logic [17:0] trial_d;
  logic        qbit_d;
  logic [16:0] pr_d;
  logic [15:0] sr_d;

  // One restoring step: shift {pr, sr} left, trial-subtract, keep on no borrow.
  always_comb begin
    trial_d = {pr_q, sr_q[15]} - {2'b00, dvs_q};
    qbit_d  = ~trial_d[17];
    pr_d    = qbit_d ? trial_d[16:0] : {pr_q[15:0], sr_q[15]};
    sr_d    = {sr_q[14:0], qbit_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dividend;
            dvs_q   <= divisor;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (dvs_q == 16'd0) begin
            dbz_q   <= 1'b1;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            state_q <= DONE;
          end else if (dvd_q[31:16] >= dvs_q) begin
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b1;
            quot_q  <= '0;
            rem_q   <= '0;
            state_q <= DONE;
          end else begin
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            pr_q    <= {1'b0, dvd_q[31:16]};
            sr_q    <= dvd_q[15:0];
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          pr_q  <= pr_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            quot_q  <= sr_d;
            rem_q   <= pr_d[15:0];
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed and random checks for seq_divider16: latency, results, flags, busy-ignore and async reset.
module tb_seq_divider16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks;
  int failures;

  seq_divider16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one operation, counts edges from the sampling edge (edge 1) to done.
  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, input logic [15:0] eq,
                        input logic [15:0] er, input logic edbz, input logic eovf, input int elat,
                        input string name);
    int lat;
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'h0; divisor = 16'h0;
    lat = 1;
    chk({name, " busy"}, {31'b0, busy}, 32'd1);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, " latency"}, lat, elat);
    chk({name, " quotient"}, {16'b0, quotient}, {16'b0, eq});
    chk({name, " remainder"}, {16'b0, remainder}, {16'b0, er});
    chk({name, " flags"}, {30'b0, div_by_zero, overflow}, {30'b0, edbz, eovf});
    @(posedge clk); #1;
    chk({name, " done pulse width"}, {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;
    logic [15:0] cq, cr;
    logic [15:0] rdvs, rhi, rlo;
    logic [31:0] rdvd;

    checks = 0; failures = 0;
    vecs[0]  = '{32'h000186A0, 16'h012C, 16'h014D, 16'h0064, 1'b0, 1'b0, 18};
    vecs[1]  = '{32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18};
    vecs[2]  = '{32'hFFFFFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b1, 2};
    vecs[3]  = '{32'h00000005, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[4]  = '{32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 18};
    vecs[5]  = '{32'h00000000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0, 18};
    vecs[6]  = '{32'h0000FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18};
    vecs[7]  = '{32'h00010000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b1, 2};
    vecs[8]  = '{32'h00010000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 1'b0, 18};
    vecs[9]  = '{32'h000003E8, 16'h03E8, 16'h0001, 16'h0000, 1'b0, 1'b0, 18};
    vecs[10] = '{32'h000003E7, 16'h03E8, 16'h0000, 16'h03E7, 1'b0, 1'b0, 18};
    vecs[11] = '{32'h00000000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};

    rst_n = 1'b0; start = 1'b0; dividend = 32'h0; divisor = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {busy, done, div_by_zero, overflow, quotient, remainder}, 36'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf,
             vecs[i].lat, $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // start pulse while busy must not disturb the running operation
    start = 1'b1; dividend = 32'h64; divisor = 16'h7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'h10; divisor = 16'h2;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'h0; divisor = 16'h0;
    ndone = 0; cq = 16'h0; cr = 16'h0;
    for (int c = 0; c < 30; c++) begin
      if (done) begin ndone++; cq = quotient; cr = remainder; end
      @(posedge clk); #1;
    end
    chk("busy ignore done count", ndone, 1);
    chk("busy ignore quotient", {16'b0, cq}, 32'h0000000E);
    chk("busy ignore remainder", {16'b0, cr}, 32'h00000002);

    // async reset during RUN
    start = 1'b1; dividend = 32'h64; divisor = 16'h7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-run reset outputs", {busy, done, div_by_zero, overflow, quotient, remainder}, 36'h0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("no done after reset abort", ndone, 0);
    run_op(32'h9, 16'h3, 16'h3, 16'h0, 1'b0, 1'b0, 18, "post-reset");

    // start held high while in DONE is only taken once back in IDLE
    start = 1'b1; dividend = 32'h3E8; divisor = 16'h3E8;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b first done", {31'b0, done}, 32'd1);
    start = 1'b1; dividend = 32'h9; divisor = 16'h3;
    @(posedge clk); #1;
    chk("start in DONE ignored", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start in IDLE accepted", {31'b0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b latency", lat, 18);
    chk("b2b quotient", {16'b0, quotient}, 32'd3);
    chk("b2b remainder", {16'b0, remainder}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 1000; k++) begin
      rdvs = 16'($urandom_range(1, 65535));
      rhi  = 16'($urandom_range(0, 32'(rdvs) - 1));
      rlo  = 16'($urandom);
      rdvd = {rhi, rlo};
      run_op(rdvd, rdvs, 16'(rdvd / {16'b0, rdvs}), 16'(rdvd % {16'b0, rdvs}), 1'b0, 1'b0, 18,
             $sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
